// File: rtl/tinv_bus_arbiter_if.sv
// Request/enable bundle between the shared-bus drivers and the TINV enable arbiter.
interface tinv_bus_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  REQ;
  logic [N-1:0]  EN;
  logic [N-1:0]  nEN;
  logic [IW-1:0] OWNER;
  logic          BUS_OWNED;

  modport master (output REQ, input EN, nEN, OWNER, BUS_OWNED);
  modport slave  (input REQ, output EN, nEN, OWNER, BUS_OWNED);
endinterface

// File: rtl/tinv_bus_arbiter.sv
// Round-robin owner selection for a shared TINV-driven bus, with a mandatory
// all-off dead-time between successive owners and an optional hold limit.
module tinv_bus_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input logic               CLK,
  input logic               RST,
  tinv_bus_arbiter_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t        state;
  logic [N-1:0]  en;
  logic [N-1:0]  n_en;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic          bus_owned;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;

  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] ptr_next;
  logic [N-1:0]  win_oh;
  logic          owner_req;
  logic          others_req;
  logic          preempt;
  logic          do_grant;
  logic          do_release;

  // First requester at or above the pointer, wrapping modulo N.
  always_comb begin
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;
    logic [IW:0]    nsum;
    req_dbl   = {bus.REQ, bus.REQ} >> ptr;
    rot       = req_dbl[N-1:0];
    sum       = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_valid && rot[i]) begin
        win_valid = 1'b1;
        sum       = (IW+1)'(ptr) + (IW+1)'(i);
        win_idx   = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      end
    end
    nsum     = (IW+1)'(win_idx) + (IW+1)'(1);
    ptr_next = (nsum == (IW+1)'(N)) ? '0 : IW'(nsum);
    win_oh   = N'(1) << win_idx;
  end

  // EN is one-hot on the owner while granted, so it doubles as the owner mask.
  assign owner_req  = |(bus.REQ & en);
  assign others_req = |(bus.REQ & ~en);
  assign preempt    = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD)) && others_req;
  assign do_grant   = win_valid &&
                      ((state == ST_IDLE) || ((state == ST_TURN) && (turn_cnt == TW'(1))));
  assign do_release = (state == ST_GRANT) && (!owner_req || preempt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      en        <= '0;
      n_en      <= '1;
      owner     <= '0;
      bus_owned <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
      turn_cnt  <= '0;
    end else if (do_grant) begin
      state     <= ST_GRANT;
      en        <= win_oh;
      n_en      <= ~win_oh;
      owner     <= win_idx;
      bus_owned <= 1'b1;
      ptr       <= ptr_next;
      hold_cnt  <= HW'(MAX_HOLD != 0);
      turn_cnt  <= '0;
    end else if (do_release) begin
      state     <= ST_TURN;
      en        <= '0;
      n_en      <= '1;
      owner     <= '0;
      bus_owned <= 1'b0;
      hold_cnt  <= '0;
      turn_cnt  <= TW'(TURNAROUND);
    end else begin
      case (state)
        ST_GRANT: begin
          if ((MAX_HOLD != 0) && (hold_cnt != HW'(MAX_HOLD)))
            hold_cnt <= hold_cnt + HW'(1);
        end
        // Dead-time expired with nobody asking: fall back to idle.
        ST_TURN: begin
          if (turn_cnt == TW'(1)) begin
            state    <= ST_IDLE;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.EN        = en;
  assign bus.nEN       = n_en;
  assign bus.OWNER     = owner;
  assign bus.BUS_OWNED = bus_owned;
endmodule

// File: tb/tb_tinv_bus_arbiter.sv
// Bench for tinv_bus_arbiter: directed scenarios plus randomized requests
// compared cycle by cycle against an owner/dead-time reference model.
module tb_tinv_bus_arbiter;
  localparam int N          = 4;
  localparam int TURNAROUND = 1;
  localparam int MAX_HOLD   = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  tinv_bus_arbiter_if #(.N(N)) bus ();

  tinv_bus_arbiter #(
    .N(N), .TURNAROUND(TURNAROUND), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: who owns the bus, how long, how much dead-time is left.
  int           m_owner = -1;
  int           m_dead  = 0;
  int           m_held  = 0;
  int           m_ptr   = 0;
  bit           mon_on  = 1'b0;
  logic [N-1:0] prev_en = '0;

  always @(posedge CLK) begin
    int r;
    int k;
    r = int'(bus.REQ);
    if (RST) begin
      m_owner = -1; m_dead = 0; m_held = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if (((r >> m_owner) & 1) == 0 ||
          (MAX_HOLD > 0 && m_held >= MAX_HOLD && (r & ~(1 << m_owner)) != 0)) begin
        m_owner = -1;
        m_dead  = TURNAROUND;
      end else begin
        m_held++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (m_owner < 0 && ((r >> k) & 1) == 1) begin
          m_owner = k;
          m_held  = 1;
        end
      end
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
    end
  end

  // Model comparison and bus-safety invariants on every cycle.
  always @(negedge CLK) begin
    logic [N-1:0] exp_en;
    int           exp_owner;
    if (mon_on) begin
      exp_en    = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      exp_owner = (m_owner >= 0) ? m_owner : 0;
      n_checks++;
      if (bus.EN !== exp_en) begin
        n_errors++;
        $display("FAIL model_en @%0t: got %b expected %b", $time, bus.EN, exp_en);
      end
      n_checks++;
      if (bus.nEN !== ~bus.EN) begin
        n_errors++;
        $display("FAIL nen_complement @%0t: got %b expected %b", $time, bus.nEN, ~bus.EN);
      end
      n_checks++;
      if (bus.BUS_OWNED !== (exp_en != '0)) begin
        n_errors++;
        $display("FAIL bus_owned @%0t: got %b expected %b", $time, bus.BUS_OWNED, exp_en != '0);
      end
      n_checks++;
      if (int'(bus.OWNER) != exp_owner) begin
        n_errors++;
        $display("FAIL owner @%0t: got %0d expected %0d", $time, bus.OWNER, exp_owner);
      end
      n_checks++;
      if (!$onehot0(bus.EN)) begin
        n_errors++;
        $display("FAIL en_onehot0 @%0t: got %b expected one-hot or zero", $time, bus.EN);
      end
      n_checks++;
      if (prev_en != '0 && bus.EN != '0 && bus.EN != prev_en) begin
        n_errors++;
        $display("FAIL dead_time @%0t: got %b after %b expected a zero cycle between", $time, bus.EN, prev_en);
      end
      prev_en = bus.EN;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] req);
    RST     = 1'b1;
    bus.REQ = req;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST     = 1'b1;
    bus.REQ = 4'b1111;
    step();
    mon_on = 1'b1;
    step();
    n_checks++;
    if (bus.EN !== 4'b0000) begin
      n_errors++; $display("FAIL reset_en: got %b expected 0000", bus.EN);
    end
    n_checks++;
    if (bus.nEN !== 4'b1111) begin
      n_errors++; $display("FAIL reset_nen: got %b expected 1111", bus.nEN);
    end
    n_checks++;
    if (bus.BUS_OWNED !== 1'b0 || bus.OWNER !== '0) begin
      n_errors++; $display("FAIL reset_owned: got %b/%0d expected 0/0", bus.BUS_OWNED, bus.OWNER);
    end
    RST = 1'b0;
    step();
    n_checks++;
    if (bus.EN !== 4'b0001) begin
      n_errors++; $display("FAIL reset_first_grant: got %b expected 0001", bus.EN);
    end
  endtask

  task automatic test_single();
    do_reset(4'b0000);
    step();
    bus.REQ = 4'b0100;
    step();
    n_checks++;
    if (bus.EN !== 4'b0100) begin
      n_errors++; $display("FAIL single_grant: got %b expected 0100", bus.EN);
    end
    repeat (9) step();
    n_checks++;
    if (bus.EN !== 4'b0100 || bus.OWNER !== 2'd2) begin
      n_errors++; $display("FAIL single_hold: got %b/%0d expected 0100/2", bus.EN, bus.OWNER);
    end
    bus.REQ = 4'b0000;
    step();
    n_checks++;
    if (bus.EN !== 4'b0000) begin
      n_errors++; $display("FAIL single_release: got %b expected 0000", bus.EN);
    end
    repeat (3) step();
    n_checks++;
    if (bus.EN !== 4'b0000 || bus.BUS_OWNED !== 1'b0) begin
      n_errors++; $display("FAIL single_idle: got %b/%b expected 0000/0", bus.EN, bus.BUS_OWNED);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset(4'b0000);
    bus.REQ = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      exp = N'(1 << (g % N));
      n_checks++;
      if (bus.EN !== exp) begin
        n_errors++; $display("FAIL rr_owner%0d: got %b expected %b", g, bus.EN, exp);
      end
      step();
      step();
      bus.REQ = 4'b1111 & ~exp;
      step();
      n_checks++;
      if (bus.EN !== 4'b0000) begin
        n_errors++; $display("FAIL rr_dead%0d: got %b expected 0000", g, bus.EN);
      end
      bus.REQ = 4'b1111;
      step();
    end
  endtask

  task automatic test_max_hold();
    do_reset(4'b0000);
    bus.REQ = 4'b0010;
    step();
    step();
    step();
    bus.REQ = 4'b1010;
    for (int c = 3; c <= 8; c++) begin
      n_checks++;
      if (bus.EN !== 4'b0010) begin
        n_errors++; $display("FAIL hold_cycle%0d: got %b expected 0010", c, bus.EN);
      end
      step();
    end
    n_checks++;
    if (bus.EN !== 4'b0000) begin
      n_errors++; $display("FAIL preempt_dead: got %b expected 0000", bus.EN);
    end
    step();
    n_checks++;
    if (bus.EN !== 4'b1000) begin
      n_errors++; $display("FAIL preempt_next: got %b expected 1000", bus.EN);
    end
    bus.REQ = 4'b0010;
    step();
    step();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (bus.EN !== 4'b0010) begin
        n_errors++; $display("FAIL alone_hold%0d: got %b expected 0010", c, bus.EN);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset(4'b0000);
    bus.REQ = 4'b0010;
    step();
    step();
    RST = 1'b1;
    step();
    n_checks++;
    if (bus.EN !== 4'b0000 || bus.nEN !== 4'b1111) begin
      n_errors++; $display("FAIL midreset_en: got %b/%b expected 0000/1111", bus.EN, bus.nEN);
    end
    RST     = 1'b0;
    bus.REQ = 4'b0011;
    step();
    n_checks++;
    if (bus.EN !== 4'b0001) begin
      n_errors++; $display("FAIL midreset_winner: got %b expected 0001", bus.EN);
    end
    // A surviving pointer would favour driver 2 here.
    do_reset(4'b0000);
    bus.REQ = 4'b0010;
    step();
    step();
    RST = 1'b1;
    step();
    RST     = 1'b0;
    bus.REQ = 4'b0110;
    step();
    n_checks++;
    if (bus.EN !== 4'b0010) begin
      n_errors++; $display("FAIL midreset_pointer: got %b expected 0010", bus.EN);
    end
  endtask

  task automatic test_random(input int cycles, input int change_odds);
    do_reset(4'b0000);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(change_odds - 1) == 0) bus.REQ = N'($urandom);
      RST = ($urandom_range(299) == 0);
      step();
    end
    RST     = 1'b0;
    bus.REQ = 4'b0000;
    step();
  endtask

  initial begin
    bus.REQ = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_hold();
    test_reset_mid_grant();
    test_random(1500, 4);
    test_random(1500, 16);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
